// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   state_e   - responder FSM state encoding (also exported on the debug port)
//   MASK_*    - common store byte-enable patterns used by requesters
//   CNT_W     - width of the latency counter (covers LATENCY up to 15)
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH_WORDS x 32 RAM, no reset.
//   clk_i     - clock
//   en_i      - port enable; with we_i=0 the addressed word is read
//   we_i      - write enable, byte lanes selected by wmask_i
//   wmask_i   - per-byte write enable (bit i -> wdata_i[8i+7:8i])
//   addr_i    - word index
//   wdata_i   - write data
//   rdata_o   - registered read data; holds its value until the next read
module dmem_array import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           en_i,
  input  logic                           we_i,
  input  logic [3:0]                     wmask_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core's load/store path. One request at a
// time; each one is answered LATENCY cycles after acceptance.
//   clk_i, rst_i       - clock, synchronous active-high reset
//   req_valid_i/req_ready_o, req_wen_i, req_addr_i, req_wdata_i, req_wmask_i
//                      - request channel (store when req_wen_i=1)
//   resp_valid_o/resp_ready_i, resp_rdata_o, resp_err_o
//                      - response channel; rdata is 0 for stores and errors
//   dbg_state_o        - current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A valid, once raised, holds its payload stable until that edge; ready
// never depends on valid. Every output is a register (or an AND of registers).
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wmask_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output state_e      dbg_state_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  // With LATENCY=1 the acceptance edge is also the edge that enters RESP.
  localparam bit          LAT1     = (LATENCY == 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic             rd_ok_q;    // response carries RAM data (in-range load)
  logic             wen_q;
  logic             inr_q;
  logic [AW-1:0]    idx_q;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  logic [31:0]   req_off;
  logic          req_inr;
  logic [AW-1:0] req_idx;
  assign req_off = req_addr_i - BASE_ADDR;
  assign req_inr = req_off < SPAN;
  assign req_idx = req_off[AW+1:2];

  logic          accept;
  logic          arr_we;
  logic          arr_rd;
  logic [AW-1:0] arr_addr;
  logic [31:0]   arr_rdata;

  assign accept = ready_q & req_valid_i & ~rst_i;
  assign arr_we = accept & req_wen_i & req_inr;

  // The single RAM port uses the live request address in IDLE (store commit,
  // or load when LATENCY=1) and the latched index when leaving WAIT.
  always_comb begin
    arr_rd   = 1'b0;
    arr_addr = idx_q;
    if (state_q == S_IDLE) begin
      arr_addr = req_idx;
      arr_rd   = LAT1 & accept & ~req_wen_i & req_inr;
    end else if (state_q == S_WAIT && cnt_q == CNT_W'(1) && !rst_i) begin
      arr_rd   = ~wen_q & inr_q;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk_i   (clk_i),
    .en_i    (arr_rd | arr_we),
    .we_i    (arr_we),
    .wmask_i (req_wmask_i),
    .addr_i  (arr_addr),
    .wdata_i (req_wdata_i),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_ok_q      <= 1'b0;
      wen_q        <= 1'b0;
      inr_q        <= 1'b0;
      idx_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            wen_q   <= req_wen_i;
            inr_q   <= req_inr;
            idx_q   <= req_idx;
            ready_q <= 1'b0;
            if (LAT1) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ~req_inr;
              rd_ok_q      <= ~req_wen_i & req_inr;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= S_RESP;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= ~inr_q;
            rd_ok_q      <= ~wen_q & inr_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          // Ready rises only after the handshake edge, so no request can be
          // taken in the same cycle as a response handshake.
          if (resp_ready_i) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_ok_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          rd_ok_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  // The RAM read register only changes on a read, never while in RESP.
  assign resp_rdata_o = arr_rdata & {32{rd_ok_q}};
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (DEPTH_WORDS=64, LATENCY=3): directed cases with
// literal expectations plus a randomized phase, all responses compared against
// a word-array reference model by one monitor process.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          LAT   = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_wen_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_wmask_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  state_e      dbg_state_o;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wen_i    (req_wen_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_wmask_i  (req_wmask_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    err_cnt++;
    $display("FAIL %s: wait bound expired, got no event expected one (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_mem [DEPTH];

  // Returns {err, rdata} for a request and applies stores to the model.
  function automatic logic [32:0] model_apply(input logic wen, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] mask);
    logic [31:0] off;
    int idx;
    off = addr - BASE;
    if (off >= 32'(DEPTH * 4)) return {1'b1, 32'h0};
    idx = int'(off / 4);
    if (wen) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) mdl_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      return {1'b0, 32'h0};
    end
    return {1'b0, mdl_mem[idx]};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [32:0] exp_q[$];
  int          acc_q[$];

  initial begin : monitor
    bit first = 1'b1;
    bit hs_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete();
        acc_q.delete();
        first   = 1'b1;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          chk("post_hs_valid", 64'(resp_valid_o), 64'(0));
          chk("post_hs_ready", 64'(req_ready_o), 64'(1));
          hs_prev = 1'b0;
        end
        if (resp_valid_o) begin
          if (exp_q.size() == 0) begin
            chk("spurious_resp", 64'(resp_valid_o), 64'(0));
          end else begin
            chk("resp_err_rdata", 64'({resp_err_o, resp_rdata_o}), 64'(exp_q[0]));
            if (first) begin
              chk("latency", 64'(cyc - acc_q[0]), 64'(LAT - 1));
              first = 1'b0;
            end
            chk("ready_in_resp", 64'(req_ready_o), 64'(0));
            if (resp_ready_i) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              first   = 1'b1;
              hs_prev = 1'b1;
            end
          end
        end
        if (req_valid_i && req_ready_o) begin
          exp_q.push_back(model_apply(req_wen_i, req_addr_i, req_wdata_i, req_wmask_i));
          acc_q.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+#1; returns at posedge+#1 right after the handshake edge.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, input int hold,
                        output logic [31:0] rd, output logic er);
    int n;
    rd = '0;
    er = 1'b0;
    req_valid_i  = 1'b1;
    req_wen_i    = wen;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_wmask_i  = mask;
    resp_ready_i = (hold == 0);
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 20) begin @(negedge clk_i); n++; end
    if (!req_ready_o) begin
      timeout("accept_wait");
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    // Request fields are free to change after acceptance.
    req_valid_i = 1'b0;
    req_wen_i   = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    req_wmask_i = 4'($urandom);
    n = 0;
    @(negedge clk_i);
    while (!resp_valid_o && n < 40) begin @(negedge clk_i); n++; end
    if (!resp_valid_o) begin
      timeout("resp_wait");
      @(posedge clk_i); #1;
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk_i);
      #1;
      resp_ready_i = 1'b1;
      @(negedge clk_i);
    end
    rd = resp_rdata_o;
    er = resp_err_o;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    logic [3:0]  masks [8];
    masks = '{MASK_BYTE, MASK_HALF, MASK_WORD, 4'b0000, 4'b0010, 4'b1100, 4'b1000, 4'b0101};

    // Reset behaviour.
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_resp_valid", 64'(resp_valid_o), 64'(0));
      chk("rst_req_ready", 64'(req_ready_o), 64'(0));
    end
    chk("rst_rdata_err", 64'({resp_err_o, resp_rdata_o}), 64'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("ready_after_rst", 64'(req_ready_o), 64'(1));
    chk("state_after_rst", 64'(dbg_state_o), 64'(S_IDLE));
    @(posedge clk_i); #1;

    // Fill the RAM so the model knows every word.
    for (int w = 0; w < DEPTH; w++)
      do_req(1'b1, BASE + 32'(w * 4), $urandom, MASK_WORD, 0, rd, er);

    // Store then load of the same word via a non-aligned address.
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, rd, er);
    chk("st_full_resp", 64'({er, rd}), 64'(0));
    do_req(1'b0, 32'h8000_0013, 32'h0, 4'b0000, 0, rd, er);
    chk("ld_full_rdata", 64'(rd), 64'(32'hDEAD_BEEF));
    chk("ld_full_err", 64'(er), 64'(0));

    // Byte-lane store.
    do_req(1'b1, 32'h8000_0020, 32'h1122_3344, 4'b1111, 0, rd, er);
    do_req(1'b1, 32'h8000_0020, 32'h0000_AA00, 4'b0010, 1, rd, er);
    do_req(1'b0, 32'h8000_0020, 32'h0, 4'b0000, 0, rd, er);
    chk("ld_byte_merge", 64'(rd), 64'(32'h1122_AA44));
    // Empty mask leaves the word alone.
    do_req(1'b1, 32'h8000_0022, 32'hFFFF_FFFF, 4'b0000, 0, rd, er);
    do_req(1'b0, 32'h8000_0020, 32'h0, 4'b0000, 0, rd, er);
    chk("ld_after_nomask", 64'(rd), 64'(32'h1122_AA44));

    // Out of range below and just above the window.
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 0, rd, er);
    chk("oor_low_resp", 64'({er, rd}), 64'({1'b1, 32'h0}));
    do_req(1'b1, BASE + 32'((DEPTH - 1) * 4), 32'hCAFE_F00D, 4'b1111, 0, rd, er);
    do_req(1'b1, BASE + 32'(DEPTH * 4), 32'h0BAD_0BAD, 4'b1111, 0, rd, er);
    chk("oor_high_st_resp", 64'({er, rd}), 64'({1'b1, 32'h0}));
    do_req(1'b0, BASE + 32'((DEPTH - 1) * 4), 32'h0, 4'b0000, 0, rd, er);
    chk("last_word_intact", 64'({er, rd}), 64'({1'b0, 32'hCAFE_F00D}));

    // Backpressure: response held 5 cycles; the monitor checks stability.
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'b0000, 5, rd, er);
    chk("bp_rdata", 64'(rd), 64'(32'hDEAD_BEEF));
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 5, rd, er);
    chk("bp_err_resp", 64'({er, rd}), 64'({1'b1, 32'h0}));

    // Reset one cycle after accepting a byte store to word 0.
    do_req(1'b1, BASE, 32'h1234_5678, MASK_WORD, 0, rd, er);
    req_valid_i  = 1'b1;
    req_wen_i    = 1'b1;
    req_addr_i   = BASE;
    req_wdata_i  = 32'h0000_0055;
    req_wmask_i  = MASK_BYTE;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rstwait_ready", 64'(req_ready_o), 64'(1));
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      chk("rstwait_no_resp", 64'(resp_valid_o), 64'(0));
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      chk("rstwait_idle_valid", 64'(resp_valid_o), 64'(0));
      chk("rstwait_idle_state", 64'(dbg_state_o), 64'(S_IDLE));
    end
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    do_req(1'b0, BASE, 32'h0, 4'b0000, 0, rd, er);
    chk("rstwait_committed", 64'(rd), 64'(32'h1234_5655));

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE - 32'($urandom_range(1, 4) * 4) + 32'($urandom_range(0, 3));
        1:       addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
        2:       addr = $urandom;
        default: addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      endcase
      do_req(1'($urandom_range(0, 1)), addr, $urandom, masks[$urandom_range(0, 7)],
             $urandom_range(0, 3), rd, er);
    end

    repeat (3) @(posedge clk_i);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the npc core: it is the memory end of the load/store path that the execute stage drives. It accepts one load or store request at a time over a valid/ready request channel, applies it to an internal word-organised RAM after a configurable latency, and returns read data and status over a valid/ready response channel. It replaces direct DPI memory calls on the data side once the core moves to a handshaked memory interface.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the RAM. Must be a power of two.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0. Must be aligned to `DEPTH_WORDS*4`.
- `LATENCY`, 1: cycles from request acceptance to `resp_valid`. Legal range is 1..15.

- `clk`  in  1  the only clock. All logic updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_wen`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address. Bits [1:0] are ignored when selecting the word.
- `req_wdata`  in  32  store data, already lane-aligned by the requester.
- `req_wmask`  in  4  per-byte store enable. Bit i enables `wdata[8i+7:8i]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester accepts the response.
- `resp_rdata`  out  32  full word containing `req_addr`. Driven 0 for stores and errors.
- `resp_err`  out  1  address was outside `[BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)`.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid && req_ready`, the request is accepted. Go to RESP if `LATENCY`=1; otherwise go to WAIT with the counter loaded to `LATENCY`-1.
  - WAIT: `req_ready`=0. The counter decrements each cycle. When the counter reaches 1, go to RESP.
  - RESP: `resp_valid`=1. On `resp_ready`, go to IDLE. Otherwise hold the state with all response outputs stable.
- Only one request is outstanding at a time. There is no pipelining.
- No request is accepted in the same cycle as a response handshake. The next request can be accepted one cycle after that handshake, at the earliest.
- Address decode:
  - in_range = (`req_addr` − `BASE_ADDR`) < `DEPTH_WORDS*4`, computed with unsigned 32-bit arithmetic.
  - word index = (`req_addr` − `BASE_ADDR`)[log2(DEPTH_WORDS)+1:2].
- Store:
  - Committed on the acceptance edge, to masked bytes only, and only when in range.
  - A mask of 4'b0000 is legal and acts as a no-op.
  - The response has `resp_rdata`=0 and `resp_err`=!in_range.
- Load:
  - The word is sampled on the edge that enters RESP, so it reflects every earlier store.
  - Sign or zero extension and byte-lane extraction using `addr[1:0]` are the requester's job.
- Out of range:
  - No RAM access takes place.
  - The response has `resp_err`=1 and `resp_rdata`=0.
- Request fields are latched at acceptance. `req_*` may change freely afterwards.

## Timing
- Reset values: state=IDLE, `req_ready`=0 while `rst`=1 and 1 in the first cycle after release, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0.
- RAM contents are not reset. They persist across `rst`.
- If a request is accepted at edge N, `resp_valid` is first high in the cycle after edge N+`LATENCY`−1, which is exactly `LATENCY` cycles later.
- `resp_valid`, `resp_rdata` and `resp_err` come straight from registers. There is no combinational path from any input to any output, except that `req_ready` is decoded from the state register only.
- Reset while in WAIT or RESP: return to IDLE and drop the pending response. A store that was already accepted stays committed.
- A request present while `rst`=1 is not accepted.

## Structure
- Shared package or header `dmem_pkg` holds:
  - the FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the mask constants MASK_BYTE=4'b0001, MASK_HALF=4'b0011, MASK_WORD=4'b1111.
- Sub-module `dmem_array`:
  - single port, `DEPTH_WORDS`×32;
  - synchronous byte-masked write and synchronous read;
  - no reset.
- `dmem_responder` owns the FSM, the latency counter, address decode and the response registers.

## Test plan
- Reset, then IDLE: `req_ready`=1 one cycle after `rst` falls, and `resp_valid`=0 throughout reset.
- Store then load, with `LATENCY`=3:
  - store 0xDEADBEEF to 0x8000_0010 with mask 4'b1111, then load 0x8000_0013;
  - each `resp_valid` appears 3 cycles after acceptance;
  - the load returns `rdata`=0xDEADBEEF and `err`=0.
- Byte store:
  - over 0x1122_3344 at 0x8000_0020, store `wdata`=0x0000_AA00 with mask 4'b0010;
  - a following load returns 0x1122_AA44.
- Out of range:
  - load 0x7FFF_FFFC returns `err`=1 and `rdata`=0;
  - store to `BASE_ADDR`+`DEPTH_WORDS*4` returns `err`=1, and a readback of word `DEPTH_WORDS`−1 is unchanged.
- Backpressure:
  - hold `resp_ready`=0 for 5 cycles;
  - `resp_valid`, `rdata` and `err` stay stable and `req_ready`=0 throughout;
  - a new request is accepted only in the cycle after the handshake.
- Reset mid-WAIT:
  - assert `rst` one cycle after accepting a store of 0x55 with mask 4'b0001 to 0x8000_0000;
  - no response is produced and the FSM is in IDLE;
  - a later load of 0x8000_0000 shows low byte 0x55.
